// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only slave: synchronises SCLK/COPI/nCS into clk and decodes
// 16-bit write frames into the five pwm_peripheral control registers.
module spi_peripheral #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_in,
   input  logic       copi_in,
   input  logic       ncs_in,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       frame_err
);

   localparam int unsigned NumRegs = 5;

   typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

   state_e                   state_q, state_d;
   logic [SYNC_STAGES-1:0]   sclk_sync_q, copi_sync_q, ncs_sync_q;
   logic                     sclk_hist_q, ncs_hist_q;
   logic [4:0]               bit_cnt_q, bit_cnt_d;
   logic [15:0]              shift_q, shift_d;
   logic [NumRegs-1:0][7:0]  regs_q, regs_d;
   logic                     wr_strobe_q, wr_strobe_d;
   logic                     frame_err_q, frame_err_d;

   logic sclk_s, copi_s, ncs_s;
   logic sclk_rise, ncs_fall, ncs_rise;
   logic frame_ok;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign copi_s = copi_sync_q[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign ncs_fall  = ~ncs_s & ncs_hist_q;
   assign ncs_rise  = ncs_s & ~ncs_hist_q;

   // Address is also bounded by the register count so a wide MAX_ADDR cannot
   // report a write that lands nowhere.
   assign frame_ok = (bit_cnt_q == 5'd16) && shift_q[15] &&
                     (shift_q[14:8] <= MAX_ADDR) && (shift_q[14:8] < 7'(NumRegs));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         ncs_sync_q  <= '1;
         sclk_hist_q <= 1'b0;
         ncs_hist_q  <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
         copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_in};
         ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_in};
         sclk_hist_q <= sclk_s;
         ncs_hist_q  <= ncs_s;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      regs_d      = regs_q;
      wr_strobe_d = 1'b0;
      frame_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ncs_fall) begin
               bit_cnt_d = '0;
               shift_d   = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            if (ncs_fall) begin
               bit_cnt_d = '0;
               shift_d   = '0;
            end else if (ncs_rise) begin
               state_d = StCommit;
            end else if (sclk_rise) begin
               shift_d = {shift_q[14:0], copi_s};
               if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
            end
         end
         StCommit: begin
            state_d = StIdle;
            if (frame_ok) begin
               for (int unsigned i = 0; i < NumRegs; i++) begin
                  if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
               end
               wr_strobe_d = 1'b1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         regs_q      <= '0;
         wr_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         regs_q      <= regs_d;
         wr_strobe_q <= wr_strobe_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign en_reg_out_7_0  = regs_q[0];
   assign en_reg_out_15_8 = regs_q[1];
   assign en_reg_pwm_7_0  = regs_q[2];
   assign en_reg_pwm_15_8 = regs_q[3];
   assign pwm_duty_cycle  = regs_q[4];
   assign wr_strobe       = wr_strobe_q;
   assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: SPI frames are driven at clk/10, the
// expected outcome of each frame is queued and checked when the DUT pulses.
module tb_spi_peripheral;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk_in = 1'b0;
   logic       copi_in = 1'b0;
   logic       ncs_in = 1'b1;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;
   logic       wr_strobe, frame_err;

   spi_peripheral dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk_in         (sclk_in),
      .copi_in         (copi_in),
      .ncs_in          (ncs_in),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .wr_strobe       (wr_strobe),
      .frame_err       (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [39:0] regs;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [7:0]  model_regs [5];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [39:0] model_snapshot();
      return {model_regs[4], model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
   endfunction

   function automatic logic [39:0] dut_snapshot();
      return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
   endfunction

   // Monitor: every strobe/error pulse consumes one expected frame outcome.
   always @(negedge clk) begin
      if (rst_n && (wr_strobe || frame_err)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event wr_strobe=%0b frame_err=%0b required no event",
                     wr_strobe, frame_err);
         end else begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({wr_strobe, frame_err} != {mon_e.wr, !mon_e.wr}) begin
               errors++;
               $display("FAIL event_kind got wr=%0b err=%0b required wr=%0b err=%0b",
                        wr_strobe, frame_err, mon_e.wr, !mon_e.wr);
            end
            checks++;
            if (dut_snapshot() !== mon_e.regs) begin
               errors++;
               $display("FAIL regs got %h required %h", dut_snapshot(), mon_e.regs);
            end
            checks++;
            if (cyc - mon_e.cyc > 4) begin
               errors++;
               $display("FAIL latency got %0d cycles required <= 4", cyc - mon_e.cyc);
            end
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (dut_snapshot() !== model_snapshot() || wr_strobe !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL %s got regs=%h wr=%b err=%b required regs=%h wr=0 err=0",
                  name, dut_snapshot(), wr_strobe, frame_err, model_snapshot());
      end
   endtask

   // Reference: only a complete 16-bit write to address 0..4 changes a register.
   task automatic expect_frame(input logic [16:0] v, input int nbits, input bit hit);
      exp_t e;
      e.wr = 1'b0;
      if (!hit && nbits == 16 && v[15] && v[14:8] <= 7'd4) begin
         model_regs[int'(v[14:8])] = v[7:0];
         e.wr = 1'b1;
      end
      e.regs = model_snapshot();
      e.cyc  = cyc;
      exp_q.push_back(e);
   endtask

   // Sends nbits of v MSB first; rst_bit >= 0 pulses rst_n during that bit.
   task automatic spi_frame(input logic [16:0] v, input int nbits, input int gap,
                            input int rst_bit);
      bit hit = 1'b0;
      @(negedge clk);
      ncs_in = 1'b0;
      wait_clk(3);
      for (int i = nbits - 1; i >= 0; i--) begin
         copi_in = v[i];
         if (nbits - 1 - i == rst_bit) begin
            wait_clk(2);
            rst_n = 1'b0;
            hit = 1'b1;
            for (int r = 0; r < 5; r++) model_regs[r] = 8'h00;
            wait_clk(1);
            check_idle("reset_mid_frame");
            wait_clk(1);
            rst_n = 1'b1;
            wait_clk(4);
         end else begin
            wait_clk(5);
         end
         sclk_in = 1'b1;
         wait_clk(5);
         sclk_in = 1'b0;
      end
      wait_clk(3);
      ncs_in = 1'b1;
      expect_frame(v, nbits, hit);
      wait_clk(gap);
   endtask

   task automatic write16(input logic [15:0] w);
      spi_frame({1'b0, w}, 16, 10, -1);
   endtask

   task automatic sclk_noise(input int n);
      for (int i = 0; i < n; i++) begin
         copi_in = 1'($urandom);
         sclk_in = 1'b1;
         wait_clk(5);
         sclk_in = 1'b0;
         wait_clk(5);
      end
   endtask

   initial begin
      logic [15:0] w;
      int          sel;
      for (int r = 0; r < 5; r++) model_regs[r] = 8'h00;
      wait_clk(3);
      check_idle("reset_state");
      rst_n = 1'b1;
      wait_clk(5);
      check_idle("after_reset_release");

      write16(16'h80F0);
      check_idle("write_addr0");
      write16(16'h8455);
      write16(16'h8180);
      write16(16'h0055);
      write16(16'h85AA);
      spi_frame({2'b00, 15'(16'h8211 >> 1)}, 15, 10, -1);
      spi_frame({16'h8211, 1'b1}, 17, 10, -1);
      check_idle("bitcount_frames");

      sclk_noise(20);
      spi_frame({1'b0, 16'h83C3}, 7, 5, -1);
      write16(16'h83C3);
      check_idle("noise_glitch");

      write16(16'h8440);
      spi_frame({1'b0, 16'h84AA}, 16, 12, 9);
      check_idle("after_reset_frame");

      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 7) == 0) sclk_noise($urandom_range(1, 6));
         w   = {1'($urandom_range(0, 3) != 0), 7'($urandom_range(0, 6)), 8'($urandom)};
         sel = $urandom_range(0, 5);
         if (sel == 0)      spi_frame({2'b00, w[15:1]}, 15, 10, -1);
         else if (sel == 1) spi_frame({w, 1'($urandom)}, 17, 10, -1);
         else               write16(w);
      end

      wait_clk(20);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events got %0d outstanding required 0", exp_q.size());
      end
      check_idle("final_regs");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
